aud_trace_buf: RTL

Trace record buffer directly downstream of the AUD branch-trace decoder. Samples the decoder's `br_addr`/`oe`/`addr_valid`/`buserror` outputs on the rising edge of `aud_ck`, turns each new branch or bus-error event into a 64-bit record with a saturating delta timestamp, and stores it in an internal FIFO. A host-side reader drains the FIFO one 32-bit word at a time. Overflow drops new records and marks the loss.

---
 rtl/aud_trace_buf.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aud_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : aud_trace_buf
// Purpose  : Captures AUD branch/bus-error events into 64-bit timestamped
//            records held in a FIFO and drained as 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module aud_trace_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_W       = 16
) (
    input  logic                aud_ck,
    input  logic                rst,
    input  logic [31:0]         br_addr,
    input  logic                oe,
    input  logic                addr_valid,
    input  logic                buserror,
    input  logic                enable,
    input  logic                rd_en,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] rec_count,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [TS_W-1:0]     c_ts_max     = '1;

    // History of the decoder outputs, sampled every cycle
    logic                  r_prev_oe;
    logic                  r_prev_buserror;
    logic [31:0]           r_last_addr;
    logic                  r_last_valid;

    logic [TS_W-1:0]       r_ts;
    logic                  r_lost;
    logic                  r_overflow;
    logic                  r_wsel;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [31:0]           r_rd_data;
    logic                  r_rd_valid;

    logic [31:0]           r_mem_w0 [c_depth];
    logic [31:0]           r_mem_w1 [c_depth];

    logic                  w_branch_ev;
    logic                  w_error_ev;
    logic                  w_event;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_rd_accept;
    logic                  w_pop;
    logic [31:0]           w_word0;
    logic [31:0]           w_word1;
    logic [31:0]           w_rd_word;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    assign w_branch_ev = enable && oe &&
                         (!r_prev_oe || (br_addr != r_last_addr) || (addr_valid != r_last_valid));
    assign w_error_ev  = enable && buserror && !r_prev_buserror;
    assign w_event     = w_branch_ev || w_error_ev;
    assign w_wr        = w_event && !w_full;
    assign w_drop      = w_event && w_full;

    // A lone error record carries a zero address and a cleared valid bit
    assign w_word0 = w_branch_ev ? br_addr : 32'h0;
    assign w_word1 = {w_branch_ev && addr_valid, w_error_ev, r_lost, 29'(r_ts)};

    assign w_rd_accept = rd_en && !w_empty;
    assign w_pop       = w_rd_accept && r_wsel;
    assign w_rd_word   = r_wsel ? r_mem_w1[r_rd_ptr] : r_mem_w0[r_rd_ptr];

    always_ff @(posedge aud_ck) begin
        if (w_wr) begin
            r_mem_w0[r_wr_ptr] <= w_word0;
            r_mem_w1[r_wr_ptr] <= w_word1;
        end
    end

    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) begin
            r_prev_oe       <= 1'b0;
            r_prev_buserror <= 1'b0;
            r_last_addr     <= 32'h0;
            r_last_valid    <= 1'b0;
            r_ts            <= '0;
            r_lost          <= 1'b0;
            r_overflow      <= 1'b0;
            r_wsel          <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_rd_data       <= 32'h0;
            r_rd_valid      <= 1'b0;
        end else begin
            r_prev_oe       <= oe;
            r_prev_buserror <= buserror;
            r_last_addr     <= br_addr;
            r_last_valid    <= addr_valid;

            if (!enable || w_event) begin
                r_ts <= '0;
            end else if (r_ts != c_ts_max) begin
                r_ts <= r_ts + 1'b1;
            end

            if (w_drop) begin
                r_lost <= 1'b1;
            end else if (w_wr) begin
                r_lost <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_wsel <= ~r_wsel;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_rd_valid <= w_rd_accept;
            r_rd_data  <= w_rd_accept ? w_rd_word : 32'h0;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign rec_count = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
